// File: rtl/prm_edge_mask_collector_if.sv
// ============================================================================
// Module      : prm_edge_mask_collector_if
// Description : Code-stream and result handshake bundle for the edge-mask
//               collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prm_edge_mask_collector_if #(
    parameter int NUM_EDGE = 64,
    parameter int CODE_W   = 15,
    parameter int CNT_W    = 16
);
    logic                code_valid;
    logic                code_ready;
    logic [CODE_W-1:0]   code_data;
    logic                code_last;
    logic                res_valid;
    logic                res_ready;
    logic [NUM_EDGE-1:0] res_blocked;
    logic [CNT_W-1:0]    res_count;

    modport master (
        output code_valid, code_data, code_last, res_ready,
        input  code_ready, res_valid, res_blocked, res_count
    );

    modport slave (
        input  code_valid, code_data, code_last, res_ready,
        output code_ready, res_valid, res_blocked, res_count
    );
endinterface

`default_nettype wire

// File: rtl/prm_edge_mask_collector.sv
// ============================================================================
// Module      : prm_edge_mask_collector
// Description : Drives obstacle codes into the checker bank, ORs the sampled
//               edge masks per frame and returns the blocked-edge vector.
//               Optional early-done/skip mode: PRM_EDGE_EARLY_DONE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prm_edge_mask_collector #(
    parameter int NUM_EDGE = 64,
    parameter int CODE_W   = 15,
    parameter int CNT_W    = 16
) (
    input  wire                 clk,
    input  wire                 rst_n,
    input  wire                 clear,
    prm_edge_mask_collector_if.slave bus,
    output logic [CODE_W-1:0]   chk_code,
    input  wire  [NUM_EDGE-1:0] chk_mask
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_OUT   = 3'd3
`ifdef PRM_EDGE_EARLY_DONE_EN
        , ST_SKIP = 3'd4
`endif
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q,    state_d;
    logic [NUM_EDGE-1:0] acc_q,      acc_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [CODE_W-1:0]   chk_code_q, chk_code_d;
    logic                s2_valid_q, s2_valid_d;
    logic                s2_last_q,  s2_last_d;
`ifdef PRM_EDGE_EARLY_DONE_EN
    logic                skip_q,     skip_d;
`endif

    logic                w_code_ready;
    logic                w_accept;
    logic                w_load;
    logic                w_early;
    logic [NUM_EDGE-1:0] w_acc_new;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        chk_code_d = chk_code_q;
        s2_valid_d = 1'b0;
        s2_last_d  = s2_last_q;
`ifdef PRM_EDGE_EARLY_DONE_EN
        skip_d     = skip_q;
`endif

        // Ready is masked by clear and reset so a code presented then is never taken.
        w_code_ready = rst_n && !clear &&
                       ((state_q == ST_IDLE) || (state_q == ST_RUN)
`ifdef PRM_EDGE_EARLY_DONE_EN
                        || (state_q == ST_SKIP)
`endif
                       );
        w_accept  = bus.code_valid && w_code_ready;
        w_acc_new = acc_q | chk_mask;
        w_early   = 1'b0;
`ifdef PRM_EDGE_EARLY_DONE_EN
        w_early   = s2_valid_q && !s2_last_q && (&w_acc_new);
`endif
        w_load    = w_accept && !w_early &&
                    ((state_q == ST_IDLE) || (state_q == ST_RUN));

        if (w_load) begin
            chk_code_d = bus.code_data;
            s2_valid_d = 1'b1;
            s2_last_d  = bus.code_last;
        end

        // Stage 2: mask reflects the code registered on the previous edge.
        if (s2_valid_q) begin
            acc_d = w_acc_new;
            if (cnt_q != C_CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (w_early) begin
                    state_d = ST_OUT;
`ifdef PRM_EDGE_EARLY_DONE_EN
                    // A last code swallowed on this edge already ends the frame.
                    skip_d  = !(w_accept && bus.code_last);
`endif
                end else if (w_accept) begin
                    state_d = bus.code_last ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (s2_valid_q && s2_last_q) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.res_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef PRM_EDGE_EARLY_DONE_EN
                    state_d = skip_q ? ST_SKIP : ST_IDLE;
                    skip_d  = 1'b0;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PRM_EDGE_EARLY_DONE_EN
            ST_SKIP: begin
                if (w_accept && bus.code_last) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            state_d    = ST_IDLE;
            acc_d      = '0;
            cnt_d      = '0;
            s2_valid_d = 1'b0;
`ifdef PRM_EDGE_EARLY_DONE_EN
            skip_d     = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            chk_code_q <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
`ifdef PRM_EDGE_EARLY_DONE_EN
            skip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            chk_code_q <= chk_code_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
`ifdef PRM_EDGE_EARLY_DONE_EN
            skip_q     <= skip_d;
`endif
        end
    end

    assign chk_code        = chk_code_q;
    assign bus.code_ready  = w_code_ready;
    assign bus.res_valid   = (state_q == ST_OUT);
    assign bus.res_blocked = acc_q;
    assign bus.res_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_prm_edge_mask_collector.sv
// ============================================================================
// Module      : tb_prm_edge_mask_collector
// Description : Directed self-checking bench; the checker bank is modelled as
//               mask = low NUM_EDGE bits of chk_code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_prm_edge_mask_collector;
    localparam int NE = 4;
    localparam int CW = 15;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic [CW-1:0] chk_code, chk_code2;
    logic [NE-1:0] chk_mask, chk_mask2;
    int            n_vec = 0;
    int            n_bad = 0;

    prm_edge_mask_collector_if #(.NUM_EDGE(NE), .CODE_W(CW), .CNT_W(16)) bus ();
    prm_edge_mask_collector_if #(.NUM_EDGE(NE), .CODE_W(CW), .CNT_W(2))  bus2 ();

    prm_edge_mask_collector #(.NUM_EDGE(NE), .CODE_W(CW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus.slave),
        .chk_code(chk_code), .chk_mask(chk_mask)
    );

    prm_edge_mask_collector #(.NUM_EDGE(NE), .CODE_W(CW), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(bus2.slave),
        .chk_code(chk_code2), .chk_mask(chk_mask2)
    );

    assign chk_mask  = chk_code[NE-1:0];
    assign chk_mask2 = chk_code2[NE-1:0];

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.code_valid = 1'b1; bus.code_data = 15'h5; bus.code_last = 1'b1;
        tick();
        n_vec++; if (bus.code_ready !== 1'b0) begin n_bad++; $display("FAIL rst_code_ready: got %b want 0", bus.code_ready); end
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        n_vec++; if (chk_code !== 15'h0) begin n_bad++; $display("FAIL rst_chk_code: got %h want 0", chk_code); end
        n_vec++; if (bus.res_count !== 16'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", bus.res_count); end
        n_vec++; if (bus.res_blocked !== 4'b0000) begin n_bad++; $display("FAIL rst_blocked: got %b want 0000", bus.res_blocked); end
        rst_n = 1'b1;
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        #1;
        n_vec++; if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL idle_code_ready: got %b want 1", bus.code_ready); end
    endtask

    task automatic test_basic_frame();
        bus.code_valid = 1'b1; bus.code_data = 15'd1; bus.code_last = 1'b0;
        tick();
        n_vec++; if (chk_code !== 15'd1) begin n_bad++; $display("FAIL basic_chk_code: got %h want 1", chk_code); end
        bus.code_data = 15'd4;
        tick();
        bus.code_data = 15'd0; bus.code_last = 1'b1;
        tick();
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        n_vec++; if (bus.code_ready !== 1'b0) begin n_bad++; $display("FAIL basic_drain_ready: got %b want 0", bus.code_ready); end
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid: got %b want 0", bus.res_valid); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid: got %b want 1", bus.res_valid); end
        n_vec++; if (bus.res_blocked !== 4'b0101) begin n_bad++; $display("FAIL basic_blocked: got %b want 0101", bus.res_blocked); end
        n_vec++; if (bus.res_count !== 16'd3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", bus.res_count); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_drop: got %b want 0", bus.res_valid); end
        n_vec++; if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL basic_idle_ready: got %b want 1", bus.code_ready); end
    endtask

    task automatic test_single_code();
        bus.code_valid = 1'b1; bus.code_data = 15'h7FFF; bus.code_last = 1'b1;
        tick();
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        n_vec++; if (chk_code !== 15'h7FFF) begin n_bad++; $display("FAIL single_chk_code: got %h want 7fff", chk_code); end
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0", bus.res_valid); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", bus.res_valid); end
        n_vec++; if (bus.res_blocked !== 4'b1111) begin n_bad++; $display("FAIL single_blocked: got %b want 1111", bus.res_blocked); end
        n_vec++; if (bus.res_count !== 16'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", bus.res_count); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_drop: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_stall();
        bus.res_ready = 1'b0;
        bus.code_valid = 1'b1; bus.code_data = 15'd2; bus.code_last = 1'b1;
        tick();
        bus.code_data = 15'd8;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, bus.res_valid); end
            n_vec++; if (bus.res_blocked !== 4'b0010) begin n_bad++; $display("FAIL stall_blocked[%0d]: got %b want 0010", i, bus.res_blocked); end
            n_vec++; if (bus.res_count !== 16'd1) begin n_bad++; $display("FAIL stall_count[%0d]: got %0d want 1", i, bus.res_count); end
            n_vec++; if (bus.code_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d]: got %b want 0", i, bus.code_ready); end
            n_vec++; if (chk_code !== 15'd2) begin n_bad++; $display("FAIL stall_chk_code[%0d]: got %h want 2", i, chk_code); end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL stall_hs_valid: got %b want 0", bus.res_valid); end
        n_vec++; if (chk_code !== 15'd2) begin n_bad++; $display("FAIL stall_hs_chk_code: got %h want 2", chk_code); end
        n_vec++; if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL stall_hs_ready: got %b want 1", bus.code_ready); end
        tick();
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        n_vec++; if (chk_code !== 15'd8) begin n_bad++; $display("FAIL stall_next_chk_code: got %h want 8", chk_code); end
        tick();
        n_vec++; if (bus.res_blocked !== 4'b1000) begin n_bad++; $display("FAIL stall_next_blocked: got %b want 1000", bus.res_blocked); end
        n_vec++; if (bus.res_count !== 16'd1) begin n_bad++; $display("FAIL stall_next_count: got %0d want 1", bus.res_count); end
        tick();
    endtask

    task automatic test_clear();
        bus.code_valid = 1'b1; bus.code_data = 15'd2; bus.code_last = 1'b0;
        tick();
        bus.code_data = 15'd8;
        tick();
        clear = 1'b1; bus.code_data = 15'd1; bus.code_last = 1'b1;
        #1;
        n_vec++; if (bus.code_ready !== 1'b0) begin n_bad++; $display("FAIL clear_ready: got %b want 0", bus.code_ready); end
        tick();
        clear = 1'b0;
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL clear_valid: got %b want 0", bus.res_valid); end
        n_vec++; if (chk_code !== 15'd8) begin n_bad++; $display("FAIL clear_chk_code: got %h want 8", chk_code); end
        n_vec++; if (bus.res_count !== 16'd0) begin n_bad++; $display("FAIL clear_count: got %0d want 0", bus.res_count); end
        n_vec++; if (bus.res_blocked !== 4'b0000) begin n_bad++; $display("FAIL clear_blocked: got %b want 0000", bus.res_blocked); end
        tick();
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL clear_next_early: got %b want 0", bus.res_valid); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL clear_next_valid: got %b want 1", bus.res_valid); end
        n_vec++; if (bus.res_blocked !== 4'b0001) begin n_bad++; $display("FAIL clear_next_blocked: got %b want 0001", bus.res_blocked); end
        n_vec++; if (bus.res_count !== 16'd1) begin n_bad++; $display("FAIL clear_next_count: got %0d want 1", bus.res_count); end
        tick();
    endtask

    task automatic test_reset_in_drain();
        bus.code_valid = 1'b1; bus.code_data = 15'd15; bus.code_last = 1'b1;
        tick();
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL rstd_valid: got %b want 0", bus.res_valid); end
        n_vec++; if (chk_code !== 15'd0) begin n_bad++; $display("FAIL rstd_chk_code: got %h want 0", chk_code); end
        #1;
        n_vec++; if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL rstd_ready: got %b want 1", bus.code_ready); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL rstd_valid_later: got %b want 0", bus.res_valid); end
        n_vec++; if (bus.res_count !== 16'd0) begin n_bad++; $display("FAIL rstd_count: got %0d want 0", bus.res_count); end
    endtask

    task automatic test_count_saturation();
        logic [CW-1:0] seq [5];
        seq = '{15'd1, 15'd1, 15'd2, 15'd4, 15'd1};
        bus2.code_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus2.code_data = seq[i];
            bus2.code_last = (i == 4);
            tick();
        end
        bus2.code_valid = 1'b0; bus2.code_last = 1'b0;
        n_vec++; if (bus2.res_valid !== 1'b0) begin n_bad++; $display("FAIL sat_early_valid: got %b want 0", bus2.res_valid); end
        tick();
        n_vec++; if (bus2.res_valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid: got %b want 1", bus2.res_valid); end
        n_vec++; if (bus2.res_count !== 2'd3) begin n_bad++; $display("FAIL sat_count: got %0d want 3", bus2.res_count); end
        n_vec++; if (bus2.res_blocked !== 4'b0111) begin n_bad++; $display("FAIL sat_blocked: got %b want 0111", bus2.res_blocked); end
        tick();
        n_vec++; if (bus2.res_valid !== 1'b0) begin n_bad++; $display("FAIL sat_valid_drop: got %b want 0", bus2.res_valid); end
    endtask

`ifdef PRM_EDGE_EARLY_DONE_EN
    task automatic test_early_done();
        bus.code_valid = 1'b1; bus.code_data = 15'd3; bus.code_last = 1'b0;
        tick();
        bus.code_data = 15'd12;
        tick();
        bus.code_data = 15'd5;
        tick();
        bus.code_data = 15'd6;
        n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL early_valid: got %b want 1", bus.res_valid); end
        n_vec++; if (bus.res_blocked !== 4'b1111) begin n_bad++; $display("FAIL early_blocked: got %b want 1111", bus.res_blocked); end
        n_vec++; if (bus.res_count !== 16'd2) begin n_bad++; $display("FAIL early_count: got %0d want 2", bus.res_count); end
        n_vec++; if (chk_code !== 15'd12) begin n_bad++; $display("FAIL early_chk_code: got %h want c", chk_code); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b0) begin n_bad++; $display("FAIL early_hs_valid: got %b want 0", bus.res_valid); end
        n_vec++; if (bus.code_ready !== 1'b1) begin n_bad++; $display("FAIL early_skip_ready: got %b want 1", bus.code_ready); end
        tick();
        bus.code_data = 15'd7; bus.code_last = 1'b1;
        n_vec++; if (chk_code !== 15'd12) begin n_bad++; $display("FAIL early_skip_chk_code: got %h want c", chk_code); end
        tick();
        bus.code_data = 15'd1;
        n_vec++; if (chk_code !== 15'd12) begin n_bad++; $display("FAIL early_skip_end_chk: got %h want c", chk_code); end
        n_vec++; if (bus.res_count !== 16'd0) begin n_bad++; $display("FAIL early_skip_count: got %0d want 0", bus.res_count); end
        tick();
        bus.code_valid = 1'b0; bus.code_last = 1'b0;
        n_vec++; if (chk_code !== 15'd1) begin n_bad++; $display("FAIL early_next_chk: got %h want 1", chk_code); end
        tick();
        n_vec++; if (bus.res_valid !== 1'b1) begin n_bad++; $display("FAIL early_next_valid: got %b want 1", bus.res_valid); end
        n_vec++; if (bus.res_count !== 16'd1) begin n_bad++; $display("FAIL early_next_count: got %0d want 1", bus.res_count); end
        tick();
    endtask
`endif

    initial begin
        bus.code_valid  = 1'b0; bus.code_data  = '0; bus.code_last  = 1'b0; bus.res_ready  = 1'b1;
        bus2.code_valid = 1'b0; bus2.code_data = '0; bus2.code_last = 1'b0; bus2.res_ready = 1'b1;
        test_reset();
        test_basic_frame();
        test_single_code();
        test_stall();
        test_clear();
        test_reset_in_drain();
        test_count_saturation();
`ifdef PRM_EDGE_EARLY_DONE_EN
        test_early_done();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/prm_edge_mask_collector.md
Name: prm_edge_mask_collector

Overview:
- Downstream consumer of the prm_oblgc_chk* obstacle-check bank.
- Accepts a stream of 15-bit obstacle codes and drives each code onto the shared checker-bank inputs A..O.
- Samples the NUM_EDGE edge_mask outputs one cycle later and ORs them into a per-edge "blocked" accumulator.
- At end of frame, emits the blocked-edge vector and a code count to the roadmap updater over a valid/ready handshake.

Parameters:
- NUM_EDGE, 64: number of checker instances (edges) in the bank; width of chk_mask and res_blocked.
- CODE_W, 15: obstacle code width; bit0 drives A, bit14 drives O.
- CNT_W, 16: width of the per-frame code counter.

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- clear, input, 1: synchronous abort of the current frame.
- code_valid, input, 1: upstream code valid.
- code_ready, output, 1: block can accept a code.
- code_data, input, CODE_W: obstacle code.
- code_last, input, 1: last code of frame; qualified by code_valid.
- chk_code, output, CODE_W: registered code driven to the checker-bank inputs.
- chk_mask, input, NUM_EDGE: edge_mask outputs of the bank; bit i comes from checker i.
- res_valid, output, 1: result valid.
- res_ready, input, 1: downstream accepts the result.
- res_blocked, output, NUM_EDGE: OR of chk_mask over all codes in the frame.
- res_count, output, CNT_W: number of codes sampled in the frame, saturating.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, accumulator=0, count=0.
  - chk_code=0, res_valid=0, code_ready=0 in the reset cycle.
  - Stage-2 valid and last flags cleared.
- States: IDLE, RUN, DRAIN, OUT.
- code_ready=1 in IDLE and RUN only. A code is accepted on code_valid & code_ready.
- Stage 1: an accepted code at edge k loads chk_code and sets s2_valid (with s2_last = code_last). chk_code holds its value when nothing is accepted.
- Stage 2: at edge k+1, if s2_valid:
  - accumulator |= chk_mask;
  - count = count+1, saturating at 2^CNT_W-1.
  - chk_mask is sampled exactly one cycle after chk_code changes, which gives the checker bank one full cycle of combinational path.
- Transitions:
  - IDLE -> RUN on an accepted code with code_last=0.
  - IDLE/RUN -> DRAIN on an accepted code with code_last=1.
  - DRAIN -> OUT when stage 2 samples the last code. res_valid goes high in the cycle after edge k+1, so latency from last acceptance to res_valid is 2 edges.
  - OUT -> IDLE on res_valid & res_ready. The accumulator and count clear on that same edge.
- res_blocked and res_count are register outputs, held stable while res_valid=1.
- Back-to-back codes: one code per cycle, sustained throughput in RUN.
- Single-code frame (code_last on the first code): IDLE -> DRAIN directly, with identical 2-edge latency.
- res_ready=0 stalls in OUT indefinitely. code_ready stays 0, so no next-frame code enters until the result handshake completes.
- clear=1 at any edge, in any state: returns to IDLE, clears accumulator, count and s2_valid, and drops res_valid with no handshake. clear takes priority over a simultaneous accept or result handshake; the code presented that cycle is not accepted.
- rst_n mid-frame: identical to clear, and additionally resets chk_code to 0.
- Count saturation: the count holds at max; the accumulator keeps ORing.

Optional Feature:
- Macro: PRM_EDGE_EARLY_DONE_EN.
- Defined:
  - Adds state SKIP.
  - If the accumulator becomes all-ones after a stage-2 sample of a non-last code, go to OUT immediately (res_count = codes sampled so far).
  - After the OUT handshake, go to SKIP instead of IDLE. SKIP holds code_ready=1 and discards codes without driving chk_code or counting them, until a code with code_last=1 is accepted, then returns to IDLE.
  - A code accepted in the same edge as the saturating sample is discarded.
  - clear in SKIP returns to IDLE.
- Undefined: no SKIP state; every frame runs to code_last.

Test Plan:
- NUM_EDGE=4; 3 codes with masks 0001, 0100, 0000 (bank model keyed on code_data); last on the third code, res_ready=1 -> res_valid 2 edges after the last acceptance, res_blocked=0101, res_count=3, then IDLE with code_ready=1.
- Single code 0x7FFF with last=1 and mask 1111 -> IDLE->DRAIN->OUT, res_blocked=1111, res_count=1; chk_code=0x7FFF one edge after acceptance.
- res_ready held 0 for 5 cycles in OUT -> res_valid, res_blocked and res_count stable; code_ready=0; first next-frame code accepted only after the handshake edge.
- clear asserted in RUN after 2 codes (masks 0010, 1000) -> no res_valid; next frame of 1 code with mask 0001 yields res_blocked=0001, res_count=1.
- rst_n low for 1 cycle while in DRAIN -> res_valid never rises, chk_code=0, state IDLE. With CNT_W=2 and a 5-code frame -> res_count=3.
- With PRM_EDGE_EARLY_DONE_EN: masks 0011 then 1100 then 3 more codes, last on the fifth -> res_blocked=1111, res_count=2 after the second sample; remaining codes discarded in SKIP; IDLE after the fifth acceptance.
